audio_synth_mixer: RTL and testbench
====================================

AUDIO_SYNTH_MIXER -- requirements
Module: audio_synth_mixer

Interface
REQ-001: The block SHALL have parameter CHANNELS, default 4, range 1..8, giving the number of voices.
REQ-002: The block SHALL have parameter PHASE_W, default 16, range 12..24, giving the per-voice phase accumulator width.
REQ-003: The block SHALL have parameter SAMPLE_DIV, default 512, giving clocks per output sample; elaboration SHALL fail if SAMPLE_DIV < CHANNELS+3.
REQ-004: The block SHALL have parameter GAIN_SH, default 3, range 0..4, giving the left shift applied to the mix before saturation.
REQ-005: The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006: clk  in  1  system clock.
REQ-007: reset  in  1  asynchronous active-high reset.
REQ-008: cfg_we  in  1  config write strobe, one write per asserted cycle, always accepted.
REQ-009: cfg_ch  in  3  target voice.
REQ-010: cfg_addr  in  2  register select: 0 freq, 1 ctrl, 2 duty, 3 phase-clear.
REQ-011: cfg_data  in  PHASE_W  write data.
REQ-012: sample_out  out  16  mixed sample, offset binary.
REQ-013: sample_valid  out  1  one-cycle pulse when sample_out updates.
REQ-014: pdm_out  out  1  first-order delta-sigma bitstream of sample_out.

Function
REQ-015: Per-voice registers SHALL be: freq[PHASE_W-1:0]; ctrl = vol[3:0] (cfg_data[3:0]), wave[1:0] (cfg_data[5:4]), en (cfg_data[6]); duty[7:0] (cfg_data[7:0]); phase[PHASE_W-1:0].
REQ-016: A write with cfg_addr=3 SHALL clear that voice's phase to 0.
REQ-017: A write with cfg_ch >= CHANNELS SHALL be ignored.
REQ-018: Tick counter SHALL count 0..SAMPLE_DIV-1 and wrap; tick SHALL assert in the cycle count==SAMPLE_DIV-1.
REQ-019: The FSM SHALL have states IDLE, ACCUM, OUTPUT; on IDLE+tick it SHALL go to ACCUM with ch=0 and acc=0.
REQ-020: In ACCUM the block SHALL process voice ch in one cycle, increment ch, and go to OUTPUT after ch=CHANNELS-1; ACCUM SHALL therefore last exactly CHANNELS cycles.
REQ-021: OUTPUT SHALL last one cycle, load sample_out, pulse sample_valid, advance the LFSR once, and return to IDLE; tick-to-sample_valid latency SHALL be CHANNELS+1 cycles.
REQ-022: Voice processing SHALL use t = phase[PHASE_W-1 -: 8] taken before the update; phase SHALL become phase+freq modulo 2^PHASE_W if en=1, and SHALL hold otherwise.
REQ-023: The waveform SHALL be signed 8-bit: wave 0 saw = t-128; 1 square = (t<duty) ? +127 : -128; 2 triangle = tri_u-128, where tri_u = t[7] ? ~{t[6:0],0} : {t[6:0],0}; 3 noise = lfsr[7:0] read as signed.
REQ-024: The contribution SHALL be wave*vol (signed 12-bit) when en=1 and 0 when en=0; acc SHALL be signed 16-bit with no overflow possible.
REQ-025: mix SHALL be acc<<GAIN_SH, saturated to [-32768, 32767]; sample_out SHALL be mix XOR 16'h8000.
REQ-026: The LFSR SHALL be 15-bit Fibonacci with taps 15,14, and SHALL never be 0.
REQ-027: PDM: each cycle {pdm_out, pacc} <= pacc + sample_out, using a 17-bit sum with pacc[15:0].
REQ-028: A config write to a voice in the same cycle that voice is processed SHALL update the register at the clock edge, so the current sample uses the old value.
REQ-029: Phase-clear SHALL override the accumulate update when both occur in the same cycle.
REQ-030: Disabling a voice mid-frame SHALL affect only voices not yet processed in that frame.

Reset
REQ-031: While reset is asserted, all voice registers, acc, ch, the tick counter and pacc SHALL be 0; the FSM SHALL be in IDLE; lfsr SHALL be 15'h0001.
REQ-032: While reset is asserted, sample_out SHALL be 16'h8000 and sample_valid and pdm_out SHALL be 0; reset asserted mid-ACCUM SHALL abort the frame with no sample_valid.
REQ-033: After reset deasserts, the first tick SHALL occur SAMPLE_DIV-1 cycles later.

Verification
REQ-034: Reset then no config -> sample_valid every 512 clocks, sample_out=16'h8000, pdm_out toggles with 50% density.
REQ-035: Voice 0 saw, vol=15, en=1, freq=0, GAIN_SH=3 -> sample_out=16'h8000 + (-128*15<<3) = 16'h4400.
REQ-036: Four voices square, vol=15, duty=255, phase=0, GAIN_SH=4 -> mix saturates, sample_out=16'hFFFF.
REQ-037: freq=16'h0100 with sample_valid counted -> t increments by 1 per sample and wraps from 255 to 0 after 256 samples.
REQ-038: Write freq to voice 2 in the cycle voice 2 is processed -> new freq first seen in the next frame; cfg_ch=5 with CHANNELS=4 -> no state change.
REQ-039: Reset pulsed mid-ACCUM -> outputs return to reset values immediately, and no sample_valid occurs until a full SAMPLE_DIV later.

Source files
------------

// File: rtl/audio_synth_mixer.sv
// Multi-voice audio synthesizer: per-voice phase accumulators and waveform shapers,
// mixed sequentially once per sample period, with gain/saturation and a PDM output.
module audio_synth_mixer #(
    parameter int CHANNELS   = 4,
    parameter int PHASE_W    = 16,
    parameter int SAMPLE_DIV = 512,
    parameter int GAIN_SH    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_ch,
    input  logic [1:0]         cfg_addr,
    input  logic [PHASE_W-1:0] cfg_data,
    output logic [15:0]        sample_out,
    output logic               sample_valid,
    output logic               pdm_out,
    output logic [1:0]         dbg_state
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NV    = 1 << CH_W;
    localparam int CNT_W = $clog2(SAMPLE_DIV);

    if (SAMPLE_DIV < CHANNELS + 3) begin : g_bad_div
        $error("audio_synth_mixer: SAMPLE_DIV must be at least CHANNELS+3");
    end
    if (CHANNELS < 1 || CHANNELS > 8 || PHASE_W < 12 || PHASE_W > 24 ||
        GAIN_SH < 0 || GAIN_SH > 4) begin : g_bad_param
        $error("audio_synth_mixer: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_e;

    state_e             state_q;
    logic [CH_W-1:0]    ch_q;
    logic signed [15:0] acc_q;
    logic [15:0]        sample_q;
    logic               valid_q;
    logic [14:0]        lfsr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        pacc_q;
    logic               pdm_q;

    logic [PHASE_W-1:0] freq_q  [NV];
    logic [PHASE_W-1:0] phase_q [NV];
    logic [3:0]         vol_q   [NV];
    logic [1:0]         wave_q  [NV];
    logic               en_q    [NV];
    logic [7:0]         duty_q  [NV];

    logic               tick;
    logic               cfg_hit;
    logic [CH_W-1:0]    cfg_idx;
    logic [7:0]         t;
    logic [7:0]         tri_u;
    logic signed [7:0]  wave_s;
    logic signed [11:0] wave_x;
    logic signed [11:0] vol_x;
    logic signed [11:0] contrib;
    logic signed [15:0] acc_d;
    logic signed [20:0] mix_wide;
    logic [15:0]        mix;

    assign tick         = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign cfg_hit      = cfg_we && (int'(cfg_ch) < CHANNELS);
    assign cfg_idx      = cfg_ch[CH_W-1:0];
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign pdm_out      = pdm_q;
    assign dbg_state    = state_q;

    // Shaper for the voice currently selected by ch_q; t is the pre-update phase.
    always_comb begin
        t     = phase_q[ch_q][PHASE_W-1 -: 8];
        tri_u = t[7] ? ~{t[6:0], 1'b0} : {t[6:0], 1'b0};
        case (wave_q[ch_q])
            2'd0:    wave_s = {~t[7], t[6:0]};
            2'd1:    wave_s = (t < duty_q[ch_q]) ? 8'sh7F : 8'sh80;
            2'd2:    wave_s = {~tri_u[7], tri_u[6:0]};
            default: wave_s = lfsr_q[7:0];
        endcase
        wave_x   = {{4{wave_s[7]}}, wave_s};
        vol_x    = {8'd0, vol_q[ch_q]};
        contrib  = en_q[ch_q] ? (wave_x * vol_x) : 12'sd0;
        acc_d    = acc_q + {{4{contrib[11]}}, contrib};
        mix_wide = {{5{acc_d[15]}}, acc_d} <<< GAIN_SH;
        if (mix_wide > 21'sd32767)       mix = 16'h7FFF;
        else if (mix_wide < -21'sd32768) mix = 16'h8000;
        else                             mix = mix_wide[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Sample is loaded on the last ACCUM edge so it is visible while OUTPUT is active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            acc_q    <= '0;
            sample_q <= 16'h8000;
            valid_q  <= 1'b0;
            lfsr_q   <= 15'h0001;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q <= ACCUM;
                        ch_q    <= '0;
                        acc_q   <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    ch_q  <= ch_q + CH_W'(1);
                    if (ch_q == CH_W'(CHANNELS - 1)) begin
                        state_q  <= OUTPUT;
                        ch_q     <= '0;
                        sample_q <= mix ^ 16'h8000;
                        valid_q  <= 1'b1;
                    end
                end
                OUTPUT: begin
                    lfsr_q  <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A phase-clear write is placed after the accumulate so it wins on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NV; i++) begin
                freq_q[i]  <= '0;
                phase_q[i] <= '0;
                vol_q[i]   <= '0;
                wave_q[i]  <= '0;
                en_q[i]    <= 1'b0;
                duty_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (state_q == ACCUM && ch_q == CH_W'(i) && en_q[i])
                    phase_q[i] <= phase_q[i] + freq_q[i];
                if (cfg_hit && cfg_idx == CH_W'(i)) begin
                    case (cfg_addr)
                        2'd0: freq_q[i] <= cfg_data;
                        2'd1: begin
                            vol_q[i]  <= cfg_data[3:0];
                            wave_q[i] <= cfg_data[5:4];
                            en_q[i]   <= cfg_data[6];
                        end
                        2'd2:    duty_q[i]  <= cfg_data[7:0];
                        default: phase_q[i] <= '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pacc_q <= '0;
            pdm_q  <= 1'b0;
        end else begin
            {pdm_q, pacc_q} <= {1'b0, pacc_q} + {1'b0, sample_q};
        end
    end

endmodule

// File: tb/tb_audio_synth_mixer.sv
// Directed bench for audio_synth_mixer: table of single-voice vectors plus
// hand-timed sequences for mixing, saturation, mid-frame writes and reset.
module tb_audio_synth_mixer;

    localparam int CHANNELS   = 4;
    localparam int PHASE_W    = 16;
    localparam int SAMPLE_DIV = 16;
    localparam int GAIN_SH    = 3;
    localparam int BUDGET     = 4 * SAMPLE_DIV;
    localparam int LAT_FIRST  = SAMPLE_DIV + CHANNELS;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cfg_we = 1'b0;
    logic [2:0]         cfg_ch = '0;
    logic [1:0]         cfg_addr = '0;
    logic [PHASE_W-1:0] cfg_data = '0;
    logic [15:0]        sample_out;
    logic               sample_valid;
    logic               pdm_out;
    logic [1:0]         dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0]  ctrl;
        logic [7:0]  duty;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[11];

    audio_synth_mixer #(
        .CHANNELS(CHANNELS), .PHASE_W(PHASE_W),
        .SAMPLE_DIV(SAMPLE_DIV), .GAIN_SH(GAIN_SH)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .sample_out(sample_out),
        .sample_valid(sample_valid), .pdm_out(pdm_out), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // scoreboard helpers
    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic apply_reset();
        reset  = 1'b1;
        cfg_we = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [1:0] addr, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_voice(input logic [2:0] ch, input logic [7:0] ctrl, input logic [7:0] duty);
        cfg_write(ch, 2'd1, {8'd0, ctrl});
        cfg_write(ch, 2'd2, {8'd0, duty});
    endtask

    // Write issued 'edges' clocks after a sample_valid edge; lands mid-ACCUM.
    task automatic timed_write(input int edges, input logic [2:0] ch, input logic [1:0] addr,
                               input logic [15:0] data);
        repeat (edges) @(posedge clk);
        #1;
        check_int("accum_at_write", int'(dbg_state), 1);
        cfg_write(ch, addr, data);
    endtask

    task automatic count_to_valid(output int n);
        n = 0;
        while (n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
            if (sample_valid) break;
        end
    endtask

    task automatic expect_sample(input string name, input logic [15:0] exp);
        int n;
        count_to_valid(n);
        if (!sample_valid) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: no sample_valid within %0d cycles", name, BUDGET);
        end else begin
            check16(name, sample_out, exp);
        end
    endtask

    initial begin
        int n;
        int ones;

        // {0, en, wave[1:0], vol[3:0]}, duty, expected sample at t=0
        vecs[0]  = '{8'h4F, 8'h00, 16'h4400};  // saw vol15
        vecs[1]  = '{8'h41, 8'h00, 16'h7C00};  // saw vol1
        vecs[2]  = '{8'h0F, 8'h00, 16'h8000};  // saw disabled
        vecs[3]  = '{8'h40, 8'h00, 16'h8000};  // saw vol0
        vecs[4]  = '{8'h5F, 8'hFF, 16'hBB88};  // square duty255
        vecs[5]  = '{8'h5F, 8'h00, 16'h4400};  // square duty0
        vecs[6]  = '{8'h58, 8'h01, 16'h9FC0};  // square duty1 vol8
        vecs[7]  = '{8'h6F, 8'h00, 16'h4400};  // triangle vol15
        vecs[8]  = '{8'h62, 8'h00, 16'h7800};  // triangle vol2
        vecs[9]  = '{8'h7F, 8'h00, 16'h8078};  // noise vol15, lfsr=1
        vecs[10] = '{8'h71, 8'h00, 16'h8008};  // noise vol1

        // reset values, first-tick latency, sample period, pdm density
        repeat (2) @(posedge clk);
        #1;
        check16("reset_sample_out", sample_out, 16'h8000);
        check_int("reset_valid", int'(sample_valid), 0);
        check_int("reset_pdm", int'(pdm_out), 0);
        check_int("reset_state", int'(dbg_state), 0);
        @(negedge clk);
        reset = 1'b0;
        count_to_valid(n);
        check_int("first_valid_latency", n, LAT_FIRST);
        check16("idle_sample", sample_out, 16'h8000);
        count_to_valid(n);
        check_int("valid_period", n, SAMPLE_DIV);
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            if (pdm_out) ones++;
        end
        check_int("pdm_density", ones, 16);

        // single-voice table
        for (int i = 0; i < 11; i++) begin
            apply_reset();
            set_voice(3'd0, vecs[i].ctrl, vecs[i].duty);
            expect_sample($sformatf("table_%0d", i), vecs[i].exp);
        end

        // noise follows the LFSR across frames
        apply_reset();
        set_voice(3'd0, 8'h7F, 8'h00);
        expect_sample("noise_f1", 16'h8078);
        expect_sample("noise_f2", 16'h80F0);
        expect_sample("noise_f3", 16'h81E0);

        // mixing and saturation
        apply_reset();
        for (int c = 0; c < 4; c++) set_voice(3'(c), 8'h5F, 8'hFF);
        expect_sample("sat_pos", 16'hFFFF);
        apply_reset();
        for (int c = 0; c < 4; c++) set_voice(3'(c), 8'h4F, 8'h00);
        expect_sample("sat_neg", 16'h0000);
        apply_reset();
        set_voice(3'd0, 8'h4F, 8'h00);
        set_voice(3'd1, 8'h5F, 8'hFF);
        expect_sample("mix_two", 16'h7F88);

        // out-of-range channel writes are ignored
        apply_reset();
        cfg_write(3'd5, 2'd1, 16'h004F);
        cfg_write(3'd4, 2'd1, 16'h004F);
        cfg_write(3'd5, 2'd0, 16'h1234);
        expect_sample("bad_ch_ignored", 16'h8000);
        cfg_write(3'd1, 2'd1, 16'h004F);
        expect_sample("good_ch_applies", 16'h4400);

        // phase advance and wrap over 257 samples
        apply_reset();
        cfg_write(3'd0, 2'd1, 16'h0041);
        cfg_write(3'd0, 2'd0, 16'h0100);
        for (int k = 0; k < 257; k++) exp_q.push_back(16'h7C00 + 16'(8 * (k % 256)));
        while (exp_q.size() > 0) expect_sample("freq_wrap", exp_q.pop_front());

        // same-cycle freq write and phase clear on voice 2
        apply_reset();
        cfg_write(3'd2, 2'd1, 16'h0041);
        cfg_write(3'd2, 2'd0, 16'h0100);
        expect_sample("sc_t0", 16'h7C00);
        expect_sample("sc_t1", 16'h7C08);
        timed_write(14, 3'd2, 2'd0, 16'h0300);
        expect_sample("sc_t2_old_freq", 16'h7C10);
        expect_sample("sc_t3", 16'h7C18);
        expect_sample("sc_t6_new_freq", 16'h7C30);
        timed_write(14, 3'd2, 2'd3, 16'h0000);
        expect_sample("sc_t9", 16'h7C48);
        expect_sample("sc_cleared", 16'h7C00);

        // mid-frame disable: voice 0 already summed, voice 3 not yet
        apply_reset();
        set_voice(3'd0, 8'h4F, 8'h00);
        set_voice(3'd3, 8'h4F, 8'h00);
        expect_sample("two_saw", 16'h0800);
        timed_write(13, 3'd0, 2'd1, 16'h0000);
        cfg_write(3'd3, 2'd1, 16'h0000);
        expect_sample("mid_disable", 16'h4400);
        expect_sample("all_disabled", 16'h8000);

        // reset mid-ACCUM aborts the frame
        apply_reset();
        set_voice(3'd0, 8'h4F, 8'h00);
        expect_sample("pre_abort", 16'h4400);
        repeat (13) @(posedge clk);
        #1;
        check_int("abort_in_accum", int'(dbg_state), 1);
        reset = 1'b1;
        #1;
        check16("abort_sample_out", sample_out, 16'h8000);
        check_int("abort_valid", int'(sample_valid), 0);
        check_int("abort_pdm", int'(pdm_out), 0);
        check_int("abort_state", int'(dbg_state), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        count_to_valid(n);
        check_int("abort_next_valid", n, LAT_FIRST);
        check16("abort_voices_cleared", sample_out, 16'h8000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
